// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline control blocks.
package arm_pkg;

  localparam int REG_COUNT       = 16;
  localparam int MEM_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: freezes the pipeline for MEM_LAT cycles per
// access and pulses mem_done in the cycle the access data is valid.
//
// state  | meaning
// IDLE   | no access; a new mem_req freezes this cycle and loads the timer
// ACCESS | access in progress, freeze held, timer counts down to 1
// DONE   | data valid, freeze released; mem_req ignored (same instr in MEM)
module mem_wait_fsm
  import arm_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze,
  output logic mem_done
);

  localparam logic [3:0] CNT_LOAD  = 4'(MEM_LAT - 1);
  localparam bit         MULTI_CYC = (MEM_LAT > 1);

  mem_state_t state;
  logic [3:0] cnt;

  // State and down-counter; the IDLE cycle itself is the first freeze cycle,
  // so the timer starts at MEM_LAT-1 and ACCESS exits on terminal count 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            cnt   <= CNT_LOAD;
            state <= MULTI_CYC ? ACCESS : DONE;
          end
        end
        ACCESS: begin
          if (cnt == 4'd1) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Freeze starts combinationally in IDLE so the requesting instruction is
  // held in MEM from its first cycle; forced low while reset is asserted.
  always_comb begin
    freeze   = rst & (((state == IDLE) & mem_req) | (state == ACCESS));
    mem_done = (state == DONE);
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline scheduler: per-register write scoreboard with RAW stall, branch
// flush of IF/ID, and the data-memory freeze sequencer.
module hazard_scheduler
  import arm_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src_1,
  input  logic [3:0]  id_src_2,
  input  logic        id_two_src,
  input  logic [3:0]  id_dest,
  input  logic        id_wb_en,
  input  logic        wb_wb_en,
  input  logic [3:0]  wb_dest,
  input  logic        mem_req,
  input  logic        exe_branch_taken,
  output logic        hazard,
  output logic        freeze,
  output logic        flush,
  output logic        mem_done,
  output logic [15:0] pending_mask
);

  logic [1:0] pend [REG_COUNT];
  logic       issue;
  logic       retire;

  mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mem_wait (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .freeze   (freeze),
    .mem_done (mem_done)
  );

  // RAW check against current counts; a same-cycle retire is not visible
  // yet, which costs one extra stall cycle but keeps this path short.
  always_comb begin
    hazard = (pend[id_src_1] != 2'd0) |
             (id_two_src & (pend[id_src_2] != 2'd0));
    issue  = id_wb_en & ~hazard & ~freeze & ~exe_branch_taken;
    retire = wb_wb_en & ~freeze;
    flush  = rst & exe_branch_taken & ~freeze;
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = issue  & (id_dest == 4'(g));
    assign dec = retire & (wb_dest == 4'(g));

    // Per-register in-flight write count; issue+retire on the same register
    // cancel, and a stray retire on an idle register is dropped.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pend[g] <= 2'd0;
      end else if (inc && !dec) begin
        pend[g] <= pend[g] + 2'd1;
      end else if (dec && !inc && (pend[g] != 2'd0)) begin
        pend[g] <= pend[g] - 2'd1;
      end
    end

    assign pending_mask[g] = (pend[g] != 2'd0);
  end

  retire_on_pending: assert property (
    @(posedge clk) disable iff (!rst) retire |-> (pend[wb_dest] != 2'd0)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural pipeline model.
module tb_hazard_scheduler;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src_1, id_src_2, id_dest, wb_dest;
  logic        id_two_src, id_wb_en, wb_wb_en, mem_req, exe_branch_taken;
  logic        hazard, freeze, flush, mem_done;
  logic [15:0] pending_mask;

  logic        mem_req1;
  logic [3:0]  z4 = 4'd0;
  logic        z1 = 1'b0;
  logic        hazard1, freeze1, flush1, mem_done1;
  logic [15:0] pending_mask1;

  int m_pend [16];
  int m_busy, m1_busy;
  bit m_done, m1_done;
  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .mem_req(mem_req),
    .exe_branch_taken(exe_branch_taken), .hazard(hazard), .freeze(freeze),
    .flush(flush), .mem_done(mem_done), .pending_mask(pending_mask)
  );

  hazard_scheduler #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .id_src_1(z4), .id_src_2(z4),
    .id_two_src(z1), .id_dest(z4), .id_wb_en(z1),
    .wb_wb_en(z1), .wb_dest(z4), .mem_req(mem_req1),
    .exe_branch_taken(z1), .hazard(hazard1), .freeze(freeze1),
    .flush(flush1), .mem_done(mem_done1), .pending_mask(pending_mask1)
  );

  // ---------------- reference model ----------------
  function automatic bit exp_hazard();
    return (m_pend[id_src_1] > 0) || (id_two_src && m_pend[id_src_2] > 0);
  endfunction

  function automatic bit exp_freeze();
    if (!rst) return 1'b0;
    return (m_busy > 0) || (!m_done && mem_req);
  endfunction

  function automatic bit exp_freeze1();
    if (!rst) return 1'b0;
    return (m1_busy > 0) || (!m1_done && mem_req1);
  endfunction

  function automatic bit exp_flush();
    return rst && exe_branch_taken && !exp_freeze();
  endfunction

  function automatic logic [15:0] exp_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (m_pend[r] > 0);
    return m;
  endfunction

  // busy = freeze cycles still owed after the current one
  task automatic mem_step(input int lat, input bit req, inout int busy, inout bit done);
    if (done) done = 1'b0;
    else if (busy > 0) begin
      busy--;
      if (busy == 0) done = 1'b1;
    end else if (req) begin
      busy = lat - 1;
      if (busy == 0) done = 1'b1;
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 16; r++) m_pend[r] = 0;
    m_busy = 0; m1_busy = 0; m_done = 1'b0; m1_done = 1'b0;
  endtask

  task automatic tick();
    bit iss, ret, req, req1;
    int d, w;
    iss  = id_wb_en && !exp_hazard() && !exp_freeze() && !exe_branch_taken;
    ret  = wb_wb_en && !exp_freeze();
    d    = int'(id_dest);
    w    = int'(wb_dest);
    req  = mem_req;
    req1 = mem_req1;
    @(posedge clk);
    if (rst) begin
      if (!(iss && ret && d == w)) begin
        if (iss) m_pend[d]++;
        if (ret && m_pend[w] > 0) m_pend[w]--;
      end
      mem_step(LAT, req, m_busy, m_done);
      mem_step(1, req1, m1_busy, m1_done);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_src_1 = 4'd0; id_src_2 = 4'd0; id_two_src = 1'b0; id_dest = 4'd0;
    id_wb_en = 1'b0; wb_wb_en = 1'b0; wb_dest = 4'd0; mem_req = 1'b0;
    exe_branch_taken = 1'b0; mem_req1 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0; mem_req = 1'b1; exe_branch_taken = 1'b1; mem_req1 = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (freeze !== 1'b0) begin errs++; $display("FAIL reset_freeze: got %b want 0", freeze); end
    vectors++; if (flush !== 1'b0) begin errs++; $display("FAIL reset_flush: got %b want 0", flush); end
    vectors++; if (mem_done !== 1'b0) begin errs++; $display("FAIL reset_mem_done: got %b want 0", mem_done); end
    vectors++; if (hazard !== 1'b0) begin errs++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL reset_mask: got %h want 0000", pending_mask); end
    vectors++; if (freeze1 !== 1'b0) begin errs++; $display("FAIL reset_freeze1: got %b want 0", freeze1); end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw();
    int stalls = 0;
    id_wb_en = 1'b1; id_dest = 4'd3; id_src_1 = 4'd0;
    #1;
    vectors++; if (hazard !== 1'b0) begin errs++; $display("FAIL raw_issue_hazard: got %b want 0", hazard); end
    tick();
    id_wb_en = 1'b0; id_src_1 = 4'd3; wb_dest = 4'd3;
    for (int c = 0; c < 5; c++) begin
      wb_wb_en = (c == 2);
      #1;
      vectors++; if (hazard !== exp_hazard()) begin errs++; $display("FAIL raw_hazard c%0d: got %b want %b", c, hazard, exp_hazard()); end
      if (hazard) stalls++;
      tick();
    end
    wb_wb_en = 1'b0;
    #1;
    vectors++; if (stalls !== 3) begin errs++; $display("FAIL raw_stall_len: got %0d want 3", stalls); end
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL raw_mask_clear: got %h want 0000", pending_mask); end
    id_src_1 = 4'd0;
  endtask

  task automatic test_two_src();
    id_wb_en = 1'b1; id_dest = 4'd5; id_src_1 = 4'd0; id_two_src = 1'b0;
    tick();
    id_wb_en = 1'b0; id_src_2 = 4'd5; id_two_src = 1'b0;
    #1;
    vectors++; if (hazard !== 1'b0) begin errs++; $display("FAIL two_src_off: got %b want 0", hazard); end
    id_two_src = 1'b1;
    #1;
    vectors++; if (hazard !== 1'b1) begin errs++; $display("FAIL two_src_on: got %b want 1", hazard); end
    vectors++; if (pending_mask !== 16'h0020) begin errs++; $display("FAIL two_src_mask: got %h want 0020", pending_mask); end
    id_two_src = 1'b0; wb_wb_en = 1'b1; wb_dest = 4'd5;
    tick();
    wb_wb_en = 1'b0;
    #1;
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL two_src_cleanup: got %h want 0000", pending_mask); end
  endtask

  task automatic test_mem_freeze();
    mem_req = 1'b1;
    for (int a = 0; a < 2; a++) begin
      int  fcnt = 0;
      bit  got_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        #1;
        vectors++; if (freeze !== exp_freeze()) begin errs++; $display("FAIL mem_freeze a%0d c%0d: got %b want %b", a, c, freeze, exp_freeze()); end
        if (freeze) fcnt++;
        if (mem_done) begin
          got_done = 1'b1;
          vectors++; if (freeze !== 1'b0) begin errs++; $display("FAIL mem_done_freeze a%0d: got %b want 0", a, freeze); end
          if (a == 1) mem_req = 1'b0;
          tick();
          break;
        end
        tick();
      end
      vectors++; if (got_done !== 1'b1) begin errs++; $display("FAIL mem_done_seen a%0d: got %b want 1", a, got_done); end
      vectors++; if (fcnt !== LAT) begin errs++; $display("FAIL mem_freeze_len a%0d: got %0d want %0d", a, fcnt, LAT); end
    end
    #1;
    vectors++; if (freeze !== 1'b0) begin errs++; $display("FAIL mem_idle_after: got %b want 0", freeze); end
  endtask

  task automatic test_simultaneous();
    id_wb_en = 1'b1; id_dest = 4'd7; id_src_1 = 4'd0;
    tick();
    wb_wb_en = 1'b1; wb_dest = 4'd7;
    tick();
    #1;
    vectors++; if (pending_mask !== 16'h0080) begin errs++; $display("FAIL sim_issue_retire: got %h want 0080", pending_mask); end
    id_wb_en = 1'b0;
    tick();
    wb_wb_en = 1'b0;
    #1;
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL sim_retire_clear: got %h want 0000", pending_mask); end
    exe_branch_taken = 1'b1; id_wb_en = 1'b1; id_dest = 4'd9;
    #1;
    vectors++; if (flush !== 1'b1) begin errs++; $display("FAIL sim_flush: got %b want 1", flush); end
    tick();
    id_wb_en = 1'b0; exe_branch_taken = 1'b0;
    #1;
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL sim_flush_noinc: got %h want 0000", pending_mask); end
    mem_req = 1'b1; exe_branch_taken = 1'b1; id_wb_en = 1'b1; id_dest = 4'd9;
    #1;
    vectors++; if (freeze !== 1'b1) begin errs++; $display("FAIL sim_frz_freeze: got %b want 1", freeze); end
    vectors++; if (flush !== exp_flush() || flush !== 1'b0) begin errs++; $display("FAIL sim_frz_flush: got %b want 0", flush); end
    tick();
    mem_req = 1'b0; exe_branch_taken = 1'b0; id_wb_en = 1'b0;
    #1;
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL sim_frz_noinc: got %h want 0000", pending_mask); end
    for (int c = 0; c < 20; c++) begin
      #1;
      vectors++; if (freeze !== exp_freeze()) begin errs++; $display("FAIL sim_drain c%0d: got %b want %b", c, freeze, exp_freeze()); end
      if (mem_done) begin tick(); break; end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int fcnt = 0;
    id_wb_en = 1'b1; id_dest = 4'd2; id_src_1 = 4'd0;
    tick();
    id_wb_en = 1'b0; mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    #1;
    vectors++; if (freeze !== 1'b1) begin errs++; $display("FAIL rmid_in_access: got %b want 1", freeze); end
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    vectors++; if (freeze !== 1'b0) begin errs++; $display("FAIL rmid_freeze: got %b want 0", freeze); end
    vectors++; if (pending_mask !== 16'h0) begin errs++; $display("FAIL rmid_mask: got %h want 0000", pending_mask); end
    vectors++; if (mem_done !== 1'b0) begin errs++; $display("FAIL rmid_done: got %b want 0", mem_done); end
    tick();
    rst = 1'b1; mem_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (freeze) fcnt++;
      if (mem_done) begin mem_req = 1'b0; tick(); break; end
      tick();
    end
    vectors++; if (fcnt !== LAT) begin errs++; $display("FAIL rmid_fresh_len: got %0d want %0d", fcnt, LAT); end
  endtask

  task automatic test_mem_lat1();
    int fcnt = 0, dcnt = 0;
    mem_req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++; if (freeze1 !== exp_freeze1()) begin errs++; $display("FAIL lat1_freeze c%0d: got %b want %b", c, freeze1, exp_freeze1()); end
      vectors++; if (mem_done1 !== m1_done) begin errs++; $display("FAIL lat1_done c%0d: got %b want %b", c, mem_done1, m1_done); end
      if (freeze1) fcnt++;
      if (mem_done1) dcnt++;
      tick();
    end
    mem_req1 = 1'b0;
    vectors++; if (fcnt !== 6 || dcnt !== 6) begin errs++; $display("FAIL lat1_counts: got %0d/%0d want 6/6", fcnt, dcnt); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int total = 0;
      for (int r = 0; r < 16; r++) total += m_pend[r];
      id_src_1         = 4'($urandom_range(0, 15));
      id_src_2         = 4'($urandom_range(0, 15));
      id_two_src       = 1'($urandom_range(0, 1));
      id_dest          = 4'($urandom_range(0, 15));
      id_wb_en         = (total < 3) && ($urandom_range(0, 1) == 1);
      wb_wb_en         = 1'b0;
      if (total > 0 && $urandom_range(0, 1) == 1) begin
        int k = $urandom_range(0, 15);
        for (int i = 0; i < 16; i++) begin
          if (m_pend[(k + i) % 16] > 0) begin
            wb_dest  = 4'((k + i) % 16);
            wb_wb_en = 1'b1;
            break;
          end
        end
      end
      mem_req          = ($urandom_range(0, 7) == 0);
      exe_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req1         = ($urandom_range(0, 2) == 0);
      #1;
      vectors++; if (hazard !== exp_hazard()) begin errs++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, hazard, exp_hazard()); end
      vectors++; if (freeze !== exp_freeze()) begin errs++; $display("FAIL rnd_freeze c%0d: got %b want %b", c, freeze, exp_freeze()); end
      vectors++; if (flush !== exp_flush()) begin errs++; $display("FAIL rnd_flush c%0d: got %b want %b", c, flush, exp_flush()); end
      vectors++; if (mem_done !== m_done) begin errs++; $display("FAIL rnd_mem_done c%0d: got %b want %b", c, mem_done, m_done); end
      vectors++; if (pending_mask !== exp_mask()) begin errs++; $display("FAIL rnd_mask c%0d: got %h want %h", c, pending_mask, exp_mask()); end
      vectors++; if (freeze1 !== exp_freeze1() || mem_done1 !== m1_done) begin errs++; $display("FAIL rnd_lat1 c%0d: got %b%b want %b%b", c, freeze1, mem_done1, exp_freeze1(), m1_done); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_two_src();
    test_mem_freeze();
    test_simultaneous();
    test_reset_mid();
    test_mem_lat1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
